// File: rtl/raycast_pkg.sv
// raycast_pkg: shared raycaster constants and the column scheduler FSM state type.
package raycast_pkg;
    localparam int SCREEN_W   = 640;
    localparam int ANGLE_W    = 10;
    localparam int ANGLE_FRAC = 8;
    localparam int ANGLE_STEP = 43;
    localparam int FOV_HALF   = 13696;
    localparam int HEIGHT_W   = 9;
    localparam int TIMEOUT    = 4095;
    localparam int CW         = $clog2(SCREEN_W);
    localparam int ACC_W      = ANGLE_W + ANGLE_FRAC;
    localparam int TCNT_W     = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/ray_column_scheduler.sv
// ray_column_scheduler: issues one ray job per screen column each frame and writes
// the returned wall heights into the column buffer.
module ray_column_scheduler
    import raycast_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [ANGLE_W-1:0]  player_angle,
    input  logic                err_clear,
    output logic                ray_start,
    output logic [ANGLE_W-1:0]  ray_angle,
    output logic [CW-1:0]       ray_col,
    input  logic                ray_done,
    input  logic [HEIGHT_W-1:0] ray_height,
    output logic                col_we,
    output logic [CW-1:0]       col_waddr,
    output logic [HEIGHT_W-1:0] col_wdata,
    output logic                busy,
    output logic                frame_done,
    output logic                err_overrun,
    output logic                err_timeout
);
    state_t              r_state, w_next;
    logic [ACC_W-1:0]    r_acc;
    logic [CW-1:0]       r_col, r_ray_col;
    logic [ANGLE_W-1:0]  r_ray_angle;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [HEIGHT_W-1:0] r_height;
    logic                r_err_overrun, r_err_timeout;
    logic                w_accept, w_busy, w_tmo, w_last;
    logic [ACC_W-1:0]    w_acc_init;

    assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
    assign w_accept   = frame_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Counter starts at 0 on the first WAIT cycle, so TIMEOUT wait cycles end at TIMEOUT-1.
    assign w_tmo      = (r_state == S_WAIT) && !ray_done && (r_tcnt == TCNT_W'(TIMEOUT - 1));
    assign w_last     = r_col == CW'(SCREEN_W - 1);
    assign w_acc_init = {player_angle, {ANGLE_FRAC{1'b0}}} - ACC_W'(FOV_HALF);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = frame_start ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (ray_done || w_tmo) ? S_WRITE : S_WAIT;
            S_WRITE: w_next = w_last ? S_DONE : S_ISSUE;
            S_DONE:  w_next = frame_start ? S_ISSUE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_col         <= '0;
            r_ray_col     <= '0;
            r_ray_angle   <= '0;
            r_tcnt        <= '0;
            r_height      <= '0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_acc <= w_acc_init;
                r_col <= '0;
            end
            if (r_state == S_WRITE && !w_last) begin
                r_col <= r_col + CW'(1);
                r_acc <= r_acc + ACC_W'(ANGLE_STEP);
            end
            r_tcnt <= (r_state == S_ISSUE) ? '0 : (r_state == S_WAIT) ? r_tcnt + TCNT_W'(1) : r_tcnt;
            if (r_state == S_ISSUE) begin
                r_ray_angle <= r_acc[ACC_W-1 -: ANGLE_W];
                r_ray_col   <= r_col;
            end
            if (r_state == S_WAIT && (ray_done || w_tmo))
                r_height <= ray_done ? ray_height : '0;
            r_err_overrun <= err_clear ? 1'b0 : (r_err_overrun || (frame_start && w_busy));
            r_err_timeout <= err_clear ? 1'b0 : (r_err_timeout || w_tmo);
        end
    end

    assign ray_start   = r_state == S_ISSUE;
    assign ray_angle   = ray_start ? r_acc[ACC_W-1 -: ANGLE_W] : r_ray_angle;
    assign ray_col     = ray_start ? r_col : r_ray_col;
    assign col_we      = r_state == S_WRITE;
    assign col_waddr   = col_we ? r_col : '0;
    assign col_wdata   = col_we ? r_height : '0;
    assign busy        = w_busy;
    assign frame_done  = r_state == S_DONE;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;
endmodule

// File: tb/tb_ray_column_scheduler.sv
// tb_ray_column_scheduler: directed scenarios for the per-frame ray column scheduler.
module tb_ray_column_scheduler;
    import raycast_pkg::*;
    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                frame_start = 1'b0;
    logic                err_clear = 1'b0;
    logic                ray_done = 1'b0;
    logic [ANGLE_W-1:0]  player_angle = '0;
    logic [HEIGHT_W-1:0] ray_height = '0;
    logic                ray_start, col_we, busy, frame_done, err_overrun, err_timeout;
    logic [ANGLE_W-1:0]  ray_angle;
    logic [CW-1:0]       ray_col, col_waddr;
    logic [HEIGHT_W-1:0] col_wdata;
    logic [8:0]          dp_h;

    int checks = 0, errors = 0, drop_col = -1;
    int cyc = 0, n_iss = 0, n_wr = 0, n_fd = 0;
    int iss_col[8192], iss_ang[8192], iss_t[8192], wr_addr[8192], wr_data[8192], wr_t[8192];

    ray_column_scheduler dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .player_angle(player_angle),
        .err_clear(err_clear), .ray_start(ray_start), .ray_angle(ray_angle), .ray_col(ray_col),
        .ray_done(ray_done), .ray_height(ray_height), .col_we(col_we), .col_waddr(col_waddr),
        .col_wdata(col_wdata), .busy(busy), .frame_done(frame_done),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (ray_start === 1'b1 && n_iss < 8192) begin
            iss_col[n_iss] = int'(ray_col);
            iss_ang[n_iss] = int'(ray_angle);
            iss_t[n_iss]   = cyc;
            n_iss++;
        end
        if (col_we === 1'b1 && n_wr < 8192) begin
            wr_addr[n_wr] = int'(col_waddr);
            wr_data[n_wr] = int'(col_wdata);
            wr_t[n_wr]    = cyc;
            n_wr++;
        end
        if (frame_done === 1'b1) n_fd++;
    end

    // Datapath model: 5-cycle latency, height = col[8:0]; drops the job at drop_col.
    initial forever begin
        @(negedge clk);
        if (ray_start === 1'b1 && int'(ray_col) != drop_col) begin
            dp_h = ray_col[8:0];
            repeat (4) @(negedge clk);
            ray_done = 1'b1;
            ray_height = dp_h;
            @(negedge clk);
            ray_done = 1'b0;
            ray_height = '0;
        end
    end

    function automatic int exp_ang(input logic [9:0] pa, input int c);
        logic [17:0] a;
        a = {pa, 8'h00} - 18'd13696 + 18'(c * 43);
        return int'(a[17:8]);
    endfunction

    task automatic start_frame(input logic [9:0] pa);
        @(negedge clk);
        player_angle = pa;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (ray_start !== 1'b1 || ray_col !== '0) begin
            errors++;
            $display("FAIL first_issue ray_start=%0b ray_col=%0d expected 1/0", ray_start, ray_col);
        end
    endtask

    task automatic wait_fd(input int bound);
        for (int k = 0; k < bound && frame_done !== 1'b1; k++) @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_wait frame_done=%0b expected 1 within %0d cycles", frame_done, bound);
        end
        @(negedge clk);
    endtask

    task automatic wait_issue(input int col, input int bound);
        for (int k = 0; k < bound && !(ray_start === 1'b1 && int'(ray_col) == col); k++) @(negedge clk);
        checks++;
        if (!(ray_start === 1'b1 && int'(ray_col) == col)) begin
            errors++;
            $display("FAIL issue_wait col=%0d got ray_start=%0b ray_col=%0d", col, ray_start, ray_col);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ray_start, busy, frame_done, col_we, err_overrun, err_timeout, ray_angle, ray_col,
             col_waddr, col_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs some output nonzero: start=%0b busy=%0b angle=%0d col=%0d", ray_start,
                     busy, ray_angle, ray_col);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        int b_i, b_w, b_f, bad_w, bad_a;
        b_i = n_iss; b_w = n_wr; b_f = n_fd; bad_w = 0; bad_a = 0;
        start_frame(10'd0);
        wait_fd(6000);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 640; i++) begin
            if (wr_addr[b_w+i] != i || wr_data[b_w+i] != (i % 512)) bad_w++;
            if (iss_ang[b_i+i] != exp_ang(10'd0, i)) bad_a++;
        end
        checks++;
        if (n_wr - b_w != 640) begin errors++; $display("FAIL full_writes got %0d expected 640", n_wr - b_w); end
        checks++;
        if (n_fd - b_f != 1) begin errors++; $display("FAIL full_frame_done got %0d expected 1", n_fd - b_f); end
        checks++;
        if (bad_w != 0) begin errors++; $display("FAIL full_write_data bad=%0d expected 0", bad_w); end
        checks++;
        if (iss_ang[b_i] != 970) begin errors++; $display("FAIL first_angle got %0d expected 970", iss_ang[b_i]); end
        checks++;
        if (bad_a != 0) begin errors++; $display("FAIL full_angles bad=%0d expected 0", bad_a); end
        checks++;
        if ({busy, err_timeout, err_overrun} !== 3'b000) begin
            errors++;
            $display("FAIL full_idle busy/tmo/ovr=%b expected 000", {busy, err_timeout, err_overrun});
        end
    endtask

    task automatic test_wrap();
        int b_i, bad_a, drops;
        b_i = n_iss; bad_a = 0; drops = 0;
        start_frame(10'd1000);
        wait_fd(6000);
        for (int i = 0; i < 640; i++) begin
            if (iss_ang[b_i+i] != exp_ang(10'd1000, i)) bad_a++;
            if (i > 0 && iss_ang[b_i+i] < iss_ang[b_i+i-1]) drops++;
        end
        checks++;
        if (iss_ang[b_i] != 946) begin errors++; $display("FAIL wrap_first got %0d expected 946", iss_ang[b_i]); end
        checks++;
        if (iss_ang[b_i+461] != 1023 || iss_ang[b_i+462] != 0) begin
            errors++;
            $display("FAIL wrap_point got %0d,%0d expected 1023,0", iss_ang[b_i+461], iss_ang[b_i+462]);
        end
        checks++;
        if (drops != 1) begin errors++; $display("FAIL wrap_monotonic drops=%0d expected 1", drops); end
        checks++;
        if (bad_a != 0) begin errors++; $display("FAIL wrap_angles bad=%0d expected 0", bad_a); end
    endtask

    task automatic test_timeout();
        int b_i, b_w, dt;
        b_i = n_iss; b_w = n_wr;
        drop_col = 100;
        start_frame(10'd0);
        wait_fd(12000);
        drop_col = -1;
        dt = wr_t[b_w+100] - iss_t[b_i+100];
        checks++;
        if (wr_addr[b_w+100] != 100 || wr_data[b_w+100] != 0) begin
            errors++;
            $display("FAIL timeout_write addr=%0d data=%0d expected 100/0", wr_addr[b_w+100], wr_data[b_w+100]);
        end
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %0b expected 1", err_timeout); end
        checks++;
        if (iss_col[b_i+101] != 101 || wr_data[b_w+101] != 101 || wr_data[b_w+99] != 99) begin
            errors++;
            $display("FAIL timeout_next col=%0d d99=%0d d101=%0d expected 101/99/101", iss_col[b_i+101],
                     wr_data[b_w+99], wr_data[b_w+101]);
        end
        checks++;
        if (dt < 4094 || dt > 4098) begin errors++; $display("FAIL timeout_delay got %0d expected ~4096", dt); end
        checks++;
        if (n_wr - b_w != 640) begin errors++; $display("FAIL timeout_writes got %0d expected 640", n_wr - b_w); end
    endtask

    task automatic test_overrun();
        int b_i, b_w, b_f, bad_c;
        b_i = n_iss; b_w = n_wr; b_f = n_fd; bad_c = 0;
        start_frame(10'd0);
        wait_issue(300, 4000);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %0b expected 1", err_overrun); end
        wait_issue(400, 4000);
        @(negedge clk);
        frame_start = 1'b1;
        err_clear = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        err_clear = 1'b0;
        checks++;
        if ({err_overrun, err_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL clear_priority flags=%b expected 00", {err_overrun, err_timeout});
        end
        wait_issue(500, 4000);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_fd(6000);
        for (int i = 0; i < 640; i++) if (iss_col[b_i+i] != i) bad_c++;
        checks++;
        if (n_iss - b_i != 640 || n_wr - b_w != 640 || n_fd - b_f != 1 || bad_c != 0) begin
            errors++;
            $display("FAIL overrun_frame iss=%0d wr=%0d fd=%0d badcol=%0d expected 640/640/1/0", n_iss - b_i,
                     n_wr - b_w, n_fd - b_f, bad_c);
        end
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b expected 1", err_overrun); end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        checks++;
        if ({err_overrun, err_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL err_clear flags=%b expected 00", {err_overrun, err_timeout});
        end
    endtask

    task automatic test_reset_mid();
        int b_i, b_w, w;
        b_w = n_wr;
        start_frame(10'd0);
        wait_issue(50, 1000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        w = n_wr;
        checks++;
        if ({ray_start, busy, frame_done, col_we, ray_angle, ray_col, col_waddr, col_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs start=%0b busy=%0b we=%0b angle=%0d col=%0d expected 0", ray_start,
                     busy, col_we, ray_angle, ray_col);
        end
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (w - b_w != 50 || n_wr != w || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write before=%0d after=%0d busy=%0b expected 50/%0d/0", w - b_w, n_wr, busy, w);
        end
        b_i = n_iss; b_w = n_wr;
        start_frame(10'd0);
        wait_fd(6000);
        checks++;
        if (iss_ang[b_i] != 970 || n_wr - b_w != 640) begin
            errors++;
            $display("FAIL reset_restart angle=%0d writes=%0d expected 970/640", iss_ang[b_i], n_wr - b_w);
        end
    endtask

    task automatic test_back_to_back();
        int b_i, b_w, b_f;
        b_i = n_iss; b_w = n_wr; b_f = n_fd;
        start_frame(10'd0);
        for (int k = 0; k < 6000 && !(col_we === 1'b1 && int'(col_waddr) == 639); k++) @(negedge clk);
        checks++;
        if (!(col_we === 1'b1 && int'(col_waddr) == 639)) begin
            errors++;
            $display("FAIL last_write we=%0b addr=%0d expected 1/639", col_we, col_waddr);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle frame_done=%0b busy=%0b expected 1/0", frame_done, busy);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (ray_start !== 1'b1 || ray_col !== '0 || frame_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_issue start=%0b col=%0d fd=%0b busy=%0b expected 1/0/0/1", ray_start, ray_col,
                     frame_done, busy);
        end
        wait_fd(6000);
        checks++;
        if (n_fd - b_f != 2 || n_wr - b_w != 1280 || n_iss - b_i != 1280 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_totals fd=%0d wr=%0d iss=%0d ovr=%0b expected 2/1280/1280/0", n_fd - b_f,
                     n_wr - b_w, n_iss - b_i, err_overrun);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_wrap();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
